// File: rtl/mem_stage_if.sv
// Data-memory req/ready bus between the MEM stage and the data memory.
// rdata is valid in the same cycle that ready is high.
interface mem_stage_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: runs the data-memory handshake, stalls while an access is
// outstanding, and drives the MEM/WB register and the MEM forward value.
module mem_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int IMM8_WIDTH = 8,
    parameter int REG_WIDTH  = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] PCM_i,
    input  logic [DATA_WIDTH-1:0] alu_outM_i,
    input  logic [DATA_WIDTH-1:0] WriteDataM_i,
    input  logic [IMM8_WIDTH-1:0] imm8M_i,
    input  logic [REG_WIDTH-1:0]  WriteRegM_i,
    input  logic                  RegWriteM_i,
    input  logic                  MemReadM_i,
    input  logic                  MemWriteM_i,
    input  logic                  MemToRegM_i,
    input  logic                  MovM_i,
    input  logic                  flush_MEM_WB_i,
    mem_stage_if.master           dmem,
    output logic                  stall_mem_o,
    output logic [DATA_WIDTH-1:0] WBResultM_o,
    output logic [ADDR_WIDTH-1:0] PCW_o,
    output logic [DATA_WIDTH-1:0] ResultW_o,
    output logic [REG_WIDTH-1:0]  WriteRegW_o,
    output logic                  RegWriteW_o,
    output logic                  mem_err_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state, stateN;
    logic [CW-1:0]         waitCnt;
    logic                  req, we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [REG_WIDTH-1:0]  writeRegL;
    logic                  regWriteL;
    logic [ADDR_WIDTH-1:0] pcL;
    logic                  memOp, start, done, abort, stall;
    logic [DATA_WIDTH-1:0] fwd;

    assign memOp = MemReadM_i | MemWriteM_i;
    assign fwd   = MovM_i ? {{(DATA_WIDTH-IMM8_WIDTH){1'b0}}, imm8M_i}
                          : alu_outM_i;

    always_comb begin
        stateN = state;
        stall  = 1'b0;
        start  = 1'b0;
        done   = 1'b0;
        abort  = 1'b0;
        unique case (state)
            IDLE: begin
                stall = memOp;
                start = memOp & ~flush_MEM_WB_i;
                if (start) stateN = ACCESS;
            end
            ACCESS: begin
                done  = dmem.ready;
                abort = ~dmem.ready & (waitCnt == TMAX);
                // a timed-out op is dropped, so the pipeline moves past it
                stall = ~dmem.ready & ~abort;
                if (done | abort) stateN = IDLE;
            end
            default: stateN = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            waitCnt   <= '0;
            req       <= 1'b0;
            we        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            writeRegL <= '0;
            regWriteL <= 1'b0;
            pcL       <= '0;
            mem_err_o <= 1'b0;
        end else begin
            state <= stateN;
            if (start) begin
                req       <= 1'b1;
                we        <= MemWriteM_i;
                addr      <= alu_outM_i[ADDR_WIDTH-1:0];
                wdata     <= WriteDataM_i;
                writeRegL <= WriteRegM_i;
                regWriteL <= RegWriteM_i & ~MemWriteM_i;
                pcL       <= PCM_i;
                waitCnt   <= '0;
            end else if (done | abort) begin
                req <= 1'b0;
            end else if (state == ACCESS) begin
                waitCnt <= waitCnt + 1'b1;
            end
            if (abort) mem_err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PCW_o       <= '0;
            ResultW_o   <= '0;
            WriteRegW_o <= '0;
            RegWriteW_o <= 1'b0;
        end else if (flush_MEM_WB_i || start || abort ||
                     (state == ACCESS && !done)) begin
            PCW_o       <= '0;
            ResultW_o   <= '0;
            WriteRegW_o <= '0;
            RegWriteW_o <= 1'b0;
        end else if (done) begin
            PCW_o       <= pcL;
            ResultW_o   <= we ? '0 : dmem.rdata;
            WriteRegW_o <= writeRegL;
            RegWriteW_o <= regWriteL;
        end else begin
            PCW_o       <= PCM_i;
            ResultW_o   <= fwd;
            WriteRegW_o <= WriteRegM_i;
            RegWriteW_o <= RegWriteM_i;
        end
    end

    assign dmem.req     = req;
    assign dmem.we      = we;
    assign dmem.addr    = addr;
    assign dmem.wdata   = wdata;
    assign stall_mem_o  = stall & ~rst;
    assign WBResultM_o  = rst ? '0 : fwd;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU/MOV capture, load, store, timeout,
// flush during access and asynchronous reset mid-access.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  PCM_i;
    logic [15:0] alu_outM_i, WriteDataM_i;
    logic [7:0]  imm8M_i;
    logic [3:0]  WriteRegM_i;
    logic        RegWriteM_i, MemReadM_i, MemWriteM_i, MemToRegM_i, MovM_i;
    logic        flush_MEM_WB_i;
    logic        stall_mem_o;
    logic [15:0] WBResultM_o, ResultW_o;
    logic [7:0]  PCW_o;
    logic [3:0]  WriteRegW_o;
    logic        RegWriteW_o, mem_err_o;

    int tests = 0;
    int fails = 0;

    mem_stage_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dmem ();

    mem_stage #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .PCM_i(PCM_i), .alu_outM_i(alu_outM_i),
        .WriteDataM_i(WriteDataM_i), .imm8M_i(imm8M_i),
        .WriteRegM_i(WriteRegM_i), .RegWriteM_i(RegWriteM_i),
        .MemReadM_i(MemReadM_i), .MemWriteM_i(MemWriteM_i),
        .MemToRegM_i(MemToRegM_i), .MovM_i(MovM_i),
        .flush_MEM_WB_i(flush_MEM_WB_i), .dmem(dmem.master),
        .stall_mem_o(stall_mem_o), .WBResultM_o(WBResultM_o),
        .PCW_o(PCW_o), .ResultW_o(ResultW_o),
        .WriteRegW_o(WriteRegW_o), .RegWriteW_o(RegWriteW_o),
        .mem_err_o(mem_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        MemReadM_i  = 0; MemWriteM_i = 0; MemToRegM_i = 0; MovM_i = 0;
        RegWriteM_i = 0; WriteRegM_i = 0; alu_outM_i = 0;
        WriteDataM_i = 0; imm8M_i = 0; PCM_i = 0;
    endtask

    task automatic load(input logic [15:0] a, input logic [3:0] rd,
                        input logic [7:0] pc);
        nop();
        MemReadM_i = 1; MemToRegM_i = 1; RegWriteM_i = 1;
        alu_outM_i = a; WriteRegM_i = rd; PCM_i = pc;
    endtask

    initial begin
        rst = 1; flush_MEM_WB_i = 0;
        dmem.ready = 0; dmem.rdata = 0;
        nop();
        #1;
        chk("rst_req",   32'(dmem.req), 0);
        chk("rst_stall", 32'(stall_mem_o), 0);
        chk("rst_rw",    32'(RegWriteW_o), 0);
        chk("rst_err",   32'(mem_err_o), 0);
        tick(); tick();
        rst = 0;

        // ALU op
        RegWriteM_i = 1; WriteRegM_i = 3; alu_outM_i = 16'h1234; PCM_i = 8'h10;
        #1;
        chk("alu_fwd",   32'(WBResultM_o), 32'h1234);
        chk("alu_stall", 32'(stall_mem_o), 0);
        tick();
        chk("alu_res", 32'(ResultW_o), 32'h1234);
        chk("alu_rd",  32'(WriteRegW_o), 3);
        chk("alu_rw",  32'(RegWriteW_o), 1);
        chk("alu_pc",  32'(PCW_o), 32'h10);

        // MOV zero-extends imm8
        MovM_i = 1; imm8M_i = 8'hA5; alu_outM_i = 16'hFFFF; WriteRegM_i = 5;
        #1;
        chk("mov_fwd", 32'(WBResultM_o), 32'h00A5);
        tick();
        chk("mov_res", 32'(ResultW_o), 32'h00A5);

        // load, ready after 3 waiting ACCESS cycles
        load(16'h1020, 4'd7, 8'h22);
        #1;
        chk("ld_stall0", 32'(stall_mem_o), 1);
        tick();
        chk("ld_req",    32'(dmem.req), 1);
        chk("ld_addr",   32'(dmem.addr), 32'h20);
        chk("ld_we",     32'(dmem.we), 0);
        chk("ld_bubble", 32'(RegWriteW_o), 0);
        chk("ld_stall1", 32'(stall_mem_o), 1);
        tick();
        chk("ld_stall2", 32'(stall_mem_o), 1);
        chk("ld_hold2",  32'(dmem.req), 1);
        tick();
        chk("ld_stall3", 32'(stall_mem_o), 1);
        tick();
        dmem.ready = 1; dmem.rdata = 16'hBEEF;
        #1;
        chk("ld_stall4", 32'(stall_mem_o), 0);
        nop();
        tick();
        dmem.ready = 0;
        chk("ld_res", 32'(ResultW_o), 32'hBEEF);
        chk("ld_rw",  32'(RegWriteW_o), 1);
        chk("ld_rd",  32'(WriteRegW_o), 7);
        chk("ld_pc",  32'(PCW_o), 32'h22);
        chk("ld_req0", 32'(dmem.req), 0);
        tick();

        // store with ready already high
        nop();
        MemWriteM_i = 1; RegWriteM_i = 1; WriteRegM_i = 2;
        alu_outM_i = 16'h0005; WriteDataM_i = 16'h00AA;
        dmem.ready = 1;
        #1;
        chk("st_stall0", 32'(stall_mem_o), 1);
        tick();
        chk("st_req",    32'(dmem.req), 1);
        chk("st_we",     32'(dmem.we), 1);
        chk("st_wdata",  32'(dmem.wdata), 32'h00AA);
        chk("st_addr",   32'(dmem.addr), 32'h05);
        chk("st_stall1", 32'(stall_mem_o), 0);
        nop();
        tick();
        dmem.ready = 0;
        chk("st_req0", 32'(dmem.req), 0);
        chk("st_rw",   32'(RegWriteW_o), 0);
        tick();

        // flush on the completing edge of a load
        load(16'h0030, 4'd4, 8'h30);
        tick();
        chk("fl_req", 32'(dmem.req), 1);
        dmem.ready = 1; dmem.rdata = 16'h1111; flush_MEM_WB_i = 1;
        #1;
        chk("fl_stall", 32'(stall_mem_o), 0);
        nop();
        tick();
        dmem.ready = 0; flush_MEM_WB_i = 0;
        chk("fl_req0", 32'(dmem.req), 0);
        chk("fl_rw",   32'(RegWriteW_o), 0);
        chk("fl_rd",   32'(WriteRegW_o), 0);
        chk("fl_res",  32'(ResultW_o), 0);
        tick();

        // timeout: ready never comes
        load(16'h0040, 4'd9, 8'h40);
        tick();
        for (int i = 1; i <= 14; i++) begin
            chk($sformatf("to_req%0d", i),   32'(dmem.req), 1);
            chk($sformatf("to_stall%0d", i), 32'(stall_mem_o), 1);
            tick();
        end
        chk("to_req15",   32'(dmem.req), 1);
        chk("to_stall15", 32'(stall_mem_o), 0);
        nop();
        RegWriteM_i = 1; WriteRegM_i = 1; alu_outM_i = 16'h0055;
        tick();
        chk("to_req0", 32'(dmem.req), 0);
        chk("to_err",  32'(mem_err_o), 1);
        chk("to_rw",   32'(RegWriteW_o), 0);
        tick();
        chk("to_next", 32'(ResultW_o), 32'h0055);
        chk("to_sticky", 32'(mem_err_o), 1);

        // async reset mid-access
        load(16'h0060, 4'd6, 8'h60);
        tick();
        tick();
        chk("rs_req", 32'(dmem.req), 1);
        #2 rst = 1;
        #1;
        chk("rs_req0",  32'(dmem.req), 0);
        chk("rs_stall", 32'(stall_mem_o), 0);
        chk("rs_err",   32'(mem_err_o), 0);
        chk("rs_rw",    32'(RegWriteW_o), 0);
        chk("rs_res",   32'(ResultW_o), 0);
        chk("rs_fwd",   32'(WBResultM_o), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
